mem_wb_stage: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline bundle.
- Drives a variable-latency data-memory bus with a req/ack handshake and stalls upstream while an access is outstanding.
- Owns the architectural HI/LO registers.
- Registers the selected writeback result into the MEM/WB outputs that feed the register file.

---
 rtl/mem_wb_stage_if.sv | 23 ++
 rtl/mem_wb_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Request side is registered by the master; the memory answers with a
// single-cycle dm_ack carrying dm_rdata.
interface mem_wb_stage_if #(
  parameter int AW = 32
) ();
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues data-memory accesses over a req/ack bus, stalls the
// pipeline while an access is outstanding, owns HI/LO and registers the
// writeback result for the register file.
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic        dm2_regM,
  input  logic        we_dmM,
  input  logic        we_regM,
  input  logic        jalM,
  input  logic        hi_loM,
  input  logic        mf_hi_loM,
  input  logic        mf_selM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] wd_dmM,
  input  logic [4:0]  rf_waM,
  input  logic [31:0] pc_plus4M,
  input  logic [31:0] hi_regM,
  input  logic [31:0] lo_regM,
  output logic        stall,
  mem_wb_stage_if.master dm,
  output logic        we_regW,
  output logic [4:0]  rf_waW,
  output logic [31:0] rf_wdW,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  // Last WAIT cycle index before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_regW_q, we_regW_d;
  logic [4:0]    rf_waW_q, rf_waW_d;
  logic [31:0]   rf_wdW_q, rf_wdW_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          bus_err_q, bus_err_d;

  logic          memop;
  logic          timeout_hit;
  logic [31:0]   wb_val;

  // Stall and writeback-source selection for the instruction sitting in MEM.
  always_comb begin
    memop       = validM & (dm2_regM | we_dmM);
    timeout_hit = (state_q == WAIT) & (cnt_q == TO_LAST) & ~dm.dm_ack;
    stall       = ((state_q == IDLE) & memop) |
                  ((state_q == WAIT) & ~dm.dm_ack & ~timeout_hit);
    if (jalM)           wb_val = pc_plus4M;
    else if (mf_hi_loM) wb_val = mf_selM ? hi_q : lo_q;
    else                wb_val = alu_outM;
  end

  // Next-state logic: issue access from IDLE, resolve ack/timeout in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_regW_d = we_regW_q;
    rf_waW_d  = rf_waW_q;
    rf_wdW_d  = rf_wdW_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    bus_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          state_d   = WAIT;
          req_d     = 1'b1;
          we_d      = we_dmM;
          addr_d    = alu_outM[AW-1:0];
          wdata_d   = wd_dmM;
          cnt_d     = '0;
          we_regW_d = 1'b0;
        end else begin
          we_regW_d = validM & we_regM;
          rf_waW_d  = rf_waM;
          rf_wdW_d  = wb_val;
          if (validM & hi_loM) begin
            hi_d = hi_regM;
            lo_d = lo_regM;
          end
        end
      end
      WAIT: begin
        cnt_d     = cnt_q + 8'd1;
        we_regW_d = 1'b0;
        if (dm.dm_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            we_regW_d = we_regM;
            rf_waW_d  = rf_waM;
            rf_wdW_d  = dm.dm_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_regW_q <= 1'b0;
      rf_waW_q  <= '0;
      rf_wdW_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_regW_q <= we_regW_d;
      rf_waW_q  <= rf_waW_d;
      rf_wdW_q  <= rf_wdW_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign we_regW     = we_regW_q;
  assign rf_waW      = rf_waW_q;
  assign rf_wdW      = rf_wdW_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases then random
// instruction stream, checked against a transaction-level model of the
// writeback/HI-LO/memory-handshake rules.
module tb_mem_wb_stage;
  localparam int TIMEOUT = 4;
  localparam int AW      = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, dm2_regM, we_dmM, we_regM, jalM, hi_loM, mf_hi_loM, mf_selM;
  logic [31:0] alu_outM, wd_dmM, pc_plus4M, hi_regM, lo_regM;
  logic [4:0]  rf_waM;
  logic        stall, we_regW, bus_err;
  logic [4:0]  rf_waW;
  logic [31:0] rf_wdW, hi_out, lo_out;

  mem_wb_stage_if #(.AW(AW)) dm_bus ();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .validM(validM), .dm2_regM(dm2_regM), .we_dmM(we_dmM), .we_regM(we_regM),
    .jalM(jalM), .hi_loM(hi_loM), .mf_hi_loM(mf_hi_loM), .mf_selM(mf_selM),
    .alu_outM(alu_outM), .wd_dmM(wd_dmM), .rf_waM(rf_waM), .pc_plus4M(pc_plus4M),
    .hi_regM(hi_regM), .lo_regM(lo_regM),
    .stall(stall), .dm(dm_bus.master),
    .we_regW(we_regW), .rf_waW(rf_waW), .rf_wdW(rf_wdW),
    .hi_out(hi_out), .lo_out(lo_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural HI/LO as the model sees them.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one instruction into MEM and follow it to completion.
  // lat = WAIT cycle (1-based) in which the memory acks, 0 = never acks.
  task automatic issue(input logic v, ld, st, wr, jal, hl, mf, sel,
                       input logic [31:0] alu, wd, input logic [4:0] wa,
                       input logic [31:0] pc4, hi, lo, rdata, input int lat);
    logic        memop;
    logic [31:0] exp_wd;
    logic        ack_now, to_now;
    @(negedge clk);
    validM = v; dm2_regM = ld; we_dmM = st; we_regM = wr; jalM = jal;
    hi_loM = hl; mf_hi_loM = mf; mf_selM = sel; alu_outM = alu; wd_dmM = wd;
    rf_waM = wa; pc_plus4M = pc4; hi_regM = hi; lo_regM = lo;
    memop = v & (ld | st);
    #1;
    chk("stall_issue", {63'd0, stall}, {63'd0, memop});
    @(posedge clk); #1;
    chk("bus_err_quiet", {63'd0, bus_err}, 64'd0);
    if (!memop) begin
      exp_wd = jal ? pc4 : (mf ? (sel ? m_hi : m_lo) : alu);
      if (v && hl) begin m_hi = hi; m_lo = lo; end
      chk("we_regW", {63'd0, we_regW}, {63'd0, v & wr});
      chk("rf_waW", {59'd0, rf_waW}, {59'd0, wa});
      chk("rf_wdW", {32'd0, rf_wdW}, {32'd0, exp_wd});
      chk("hi_out", {32'd0, hi_out}, {32'd0, m_hi});
      chk("lo_out", {32'd0, lo_out}, {32'd0, m_lo});
      chk("dm_req_idle", {63'd0, dm_bus.dm_req}, 64'd0);
    end else begin
      chk("dm_req_issue", {63'd0, dm_bus.dm_req}, 64'd1);
      chk("dm_we", {63'd0, dm_bus.dm_we}, {63'd0, st});
      chk("dm_addr", {32'd0, dm_bus.dm_addr}, {32'd0, alu});
      chk("dm_wdata", {32'd0, dm_bus.dm_wdata}, {32'd0, wd});
      chk("we_regW_bubble", {63'd0, we_regW}, 64'd0);
      for (int k = 1; k <= TIMEOUT; k++) begin
        ack_now = (k == lat);
        to_now  = !ack_now && (k == TIMEOUT);
        @(negedge clk);
        dm_bus.dm_ack   = ack_now;
        dm_bus.dm_rdata = ack_now ? rdata : 32'h0;
        #1;
        chk("stall_wait", {63'd0, stall}, {63'd0, !ack_now && !to_now});
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0;
        if (ack_now) begin
          chk("dm_req_ack", {63'd0, dm_bus.dm_req}, 64'd0);
          chk("bus_err_ack", {63'd0, bus_err}, 64'd0);
          chk("we_regW_ack", {63'd0, we_regW}, {63'd0, !st && wr});
          if (!st) begin
            chk("rf_waW_ld", {59'd0, rf_waW}, {59'd0, wa});
            chk("rf_wdW_ld", {32'd0, rf_wdW}, {32'd0, rdata});
          end
          break;
        end else if (to_now) begin
          chk("dm_req_to", {63'd0, dm_bus.dm_req}, 64'd0);
          chk("bus_err_to", {63'd0, bus_err}, 64'd1);
          chk("we_regW_to", {63'd0, we_regW}, 64'd0);
          break;
        end else begin
          chk("dm_req_hold", {63'd0, dm_bus.dm_req}, 64'd1);
          chk("dm_addr_hold", {32'd0, dm_bus.dm_addr}, {32'd0, alu});
          chk("we_regW_wait", {63'd0, we_regW}, 64'd0);
        end
      end
    end
  endtask

  initial begin
    int kind;
    logic v, ld, st, wr, jal, hl, mf, sel;
    rst = 1'b1;
    validM = 0; dm2_regM = 0; we_dmM = 0; we_regM = 0; jalM = 0; hi_loM = 0;
    mf_hi_loM = 0; mf_selM = 0; alu_outM = 0; wd_dmM = 0; rf_waM = 0;
    pc_plus4M = 0; hi_regM = 0; lo_regM = 0;
    dm_bus.dm_ack = 0; dm_bus.dm_rdata = 0;
    #1;
    chk("rst_dm_req", {63'd0, dm_bus.dm_req}, 64'd0);
    chk("rst_we_regW", {63'd0, we_regW}, 64'd0);
    chk("rst_rf_wdW", {32'd0, rf_wdW}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // ALU op
    issue(1,0,0,1,0,0,0,0, 32'h1234, 0, 5'd5, 0, 0, 0, 0, 0);
    // load with ack in third WAIT cycle
    issue(1,1,0,1,0,0,0,0, 32'h40, 0, 5'd7, 0, 0, 0, 32'hDEADBEEF, 3);
    // store with immediate ack
    issue(1,0,1,0,0,0,0,0, 32'h80, 32'hA5A5A5A5, 5'd0, 0, 0, 0, 0, 1);
    // commit HI/LO then read back-to-back
    issue(1,0,0,0,0,1,0,0, 0, 0, 5'd0, 0, 32'h11, 32'h22, 0, 0);
    issue(1,0,0,1,0,0,1,1, 32'h5, 0, 5'd3, 0, 0, 0, 0, 0);
    issue(1,0,0,1,0,0,1,0, 32'h6, 0, 5'd4, 0, 0, 0, 0, 0);
    // jal, then bubble
    issue(1,0,0,1,1,0,0,0, 32'h99, 0, 5'd31, 32'h400004, 0, 0, 0, 0);
    issue(0,0,0,1,0,0,0,0, 32'h77, 0, 5'd9, 0, 0, 0, 0, 0);
    // load that never acks, and ack on the very last WAIT cycle
    issue(1,1,0,1,0,0,0,0, 32'h100, 0, 5'd8, 0, 0, 0, 0, 0);
    issue(1,1,0,1,0,0,0,0, 32'h104, 0, 5'd8, 0, 0, 0, 32'hCAFEF00D, TIMEOUT);

    // reset in the middle of a WAIT
    @(negedge clk);
    validM = 1; dm2_regM = 1; we_dmM = 0; we_regM = 1; alu_outM = 32'h200;
    @(posedge clk); #1;
    chk("rst_mid_req_before", {63'd0, dm_bus.dm_req}, 64'd1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_mid_req", {63'd0, dm_bus.dm_req}, 64'd0);
    chk("rst_mid_addr", {32'd0, dm_bus.dm_addr}, 64'd0);
    chk("rst_mid_we_regW", {63'd0, we_regW}, 64'd0);
    chk("rst_mid_wb", {27'd0, rf_waW, rf_wdW}, 64'd0);
    chk("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
    chk("rst_mid_bus_err", {63'd0, bus_err}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    validM = 0; rst = 1'b0;

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      v   = ($urandom_range(0, 9) != 0);
      ld  = (kind == 1); st = (kind == 2);
      wr  = $urandom_range(0, 1);
      jal = (kind == 3);
      mf  = (kind == 4) || (kind == 3 && $urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 1);
      hl  = (kind == 5);
      issue(v, ld, st, wr, jal, hl, mf, sel, $urandom, $urandom,
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, TIMEOUT));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
